alu_issue_stage: RTL and testbench

Decode/operand-fetch stage that drives the ALU's operand and function inputs. Accepts one RV32I integer-ALU instruction per cycle over a valid/ready handshake, reads operands from an internal 32x32 register file with a writeback port, generates immediates, and presents `x`, `y`, `funct3` and `funct7` in a registered output slot. The output slot connects directly to the ALU inputs, with a downstream valid/ready handshake.

---
 rtl/alu_issue_stage.sv | 151 +++++++++++++++
 tb/tb_alu_issue_stage.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_stage.sv
// RV32I integer-ALU issue stage: decodes one instruction, reads the register file
// (with writeback bypass), and holds x/y/funct3/funct7 in a single output slot.
module alu_issue_stage #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    input  logic            wb_en,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_x,
    output logic [XLEN-1:0] out_y,
    output logic [3:0]      out_funct3,
    output logic [6:0]      out_funct7,
    output logic [4:0]      out_rd,
    output logic            out_rd_we,
    output logic            out_illegal
);
    localparam logic [6:0] OP_REG = 7'b0110011;
    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] OP_LUI = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    logic [XLEN-1:0] regs [0:31];

    logic [6:0]      opcode;
    logic [2:0]      f3_raw;
    logic [6:0]      f7_raw;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] rs2_val;
    logic signed [XLEN-1:0] imm_i;
    logic [XLEN-1:0] imm_u;

    logic            legal_p0;
    logic [XLEN-1:0] x_p0;
    logic [XLEN-1:0] y_p0;
    logic [2:0]      f3_p0;
    logic [6:0]      f7_p0;
    logic            accept;

    assign opcode = in_instr[6:0];
    assign rd     = in_instr[11:7];
    assign f3_raw = in_instr[14:12];
    assign rs1    = in_instr[19:15];
    assign rs2    = in_instr[24:20];
    assign f7_raw = in_instr[31:25];
    assign imm_i  = $signed({{20{in_instr[31]}}, in_instr[31:20]});
    assign imm_u  = {in_instr[31:12], 12'b0};

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    // A writeback landing on the accept edge is forwarded so the operand is never stale.
    function automatic logic [XLEN-1:0] read_reg(input logic [4:0] idx, input logic [XLEN-1:0] stored);
        if (idx == 5'd0)
            return '0;
        else if (wb_en && wb_rd == idx)
            return wb_data;
        else
            return stored;
    endfunction

    assign rs1_val = read_reg(rs1, regs[rs1]);
    assign rs2_val = read_reg(rs2, regs[rs2]);

    always_comb begin
        legal_p0 = 1'b1;
        x_p0     = '0;
        y_p0     = '0;
        f3_p0    = f3_raw;
        f7_p0    = 7'h00;
        case (opcode)
            OP_REG: begin
                x_p0     = rs1_val;
                y_p0     = rs2_val;
                f7_p0    = f7_raw;
                legal_p0 = (f7_raw == 7'h00) ||
                           (f7_raw == 7'h20 && (f3_raw == 3'b000 || f3_raw == 3'b101));
            end
            OP_IMM: begin
                x_p0 = rs1_val;
                if (f3_raw == 3'b001 || f3_raw == 3'b101) begin
                    y_p0     = {{(XLEN-5){1'b0}}, in_instr[24:20]};
                    f7_p0    = f7_raw;
                    legal_p0 = (f7_raw == 7'h00) || (f3_raw == 3'b101 && f7_raw == 7'h20);
                end else begin
                    // funct7 forced to 0 so a negative ADDI is never treated as SUB
                    y_p0 = imm_i;
                end
            end
            OP_LUI: begin
                y_p0  = imm_u;
                f3_p0 = 3'b000;
            end
            OP_AUIPC: begin
                x_p0  = in_pc;
                y_p0  = imm_u;
                f3_p0 = 3'b000;
            end
            default: legal_p0 = 1'b0;
        endcase
        if (!legal_p0) begin
            x_p0  = '0;
            y_p0  = '0;
            f3_p0 = 3'b000;
            f7_p0 = 7'h00;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) regs[i] <= '0;
        end else if (wb_en && wb_rd != 5'd0) begin
            regs[wb_rd] <= wb_data;
        end
    end

    // Output slot boundary: loaded on accept, drained when downstream takes it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid   <= 1'b0;
            out_x       <= '0;
            out_y       <= '0;
            out_funct3  <= '0;
            out_funct7  <= '0;
            out_rd      <= '0;
            out_rd_we   <= 1'b0;
            out_illegal <= 1'b0;
        end else if (accept) begin
            out_valid   <= 1'b1;
            out_x       <= x_p0;
            out_y       <= y_p0;
            out_funct3  <= {1'b0, f3_p0};
            out_funct7  <= f7_p0;
            out_rd      <= rd;
            out_rd_we   <= legal_p0 && (rd != 5'd0);
            out_illegal <= !legal_p0;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_alu_issue_stage.sv
// Scoreboard bench for alu_issue_stage: a driver predicts each accepted instruction
// from a register-file model, a monitor compares whatever the output slot presents.
module tb_alu_issue_stage;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic        wb_en;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_x;
    logic [31:0] out_y;
    logic [3:0]  out_funct3;
    logic [6:0]  out_funct7;
    logic [4:0]  out_rd;
    logic        out_rd_we;
    logic        out_illegal;

    alu_issue_stage #(.XLEN(32)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
        .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_x(out_x), .out_y(out_y), .out_funct3(out_funct3), .out_funct7(out_funct7),
        .out_rd(out_rd), .out_rd_we(out_rd_we), .out_illegal(out_illegal)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] x;
        logic [31:0] y;
        logic [3:0]  f3;
        logic [6:0]  f7;
        logic [4:0]  rd;
        logic        we;
        logic        ill;
    } exp_t;

    exp_t        q[$];
    logic [31:0] mregs [0:31];
    logic        slot_full = 1'b0;
    logic        started = 1'b0;
    int          vectors = 0;
    int          errs = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] opnd(input logic [4:0] r, input logic we,
                                         input logic [4:0] wr, input logic [31:0] wd);
        if (r == 0) return 32'h0;
        if (we && wr == r) return wd;
        return mregs[r];
    endfunction

    // Reference decode straight from the RV32I ALU encoding rules.
    function automatic exp_t model(input logic [31:0] ins, input logic [31:0] pc,
                                   input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        int   op = int'(ins[6:0]);
        int   f3 = int'(ins[14:12]);
        int   f7 = int'(ins[31:25]);
        int   simm = int'($signed(ins[31:20]));
        bit   ok = 1'b0;
        e.x = 0; e.y = 0; e.f3 = 0; e.f7 = 0;
        if (op == 'h33) begin
            ok = (f7 == 0) || (f7 == 'h20 && (f3 == 0 || f3 == 5));
            e.x = a; e.y = b; e.f3 = 4'(f3); e.f7 = 7'(f7);
        end else if (op == 'h13 && (f3 == 1 || f3 == 5)) begin
            ok = (f7 == 0) || (f3 == 5 && f7 == 'h20);
            e.x = a; e.y = 32'(ins[24:20]); e.f3 = 4'(f3); e.f7 = 7'(f7);
        end else if (op == 'h13) begin
            ok = 1'b1;
            e.x = a; e.y = 32'(simm); e.f3 = 4'(f3);
        end else if (op == 'h37 || op == 'h17) begin
            ok = 1'b1;
            e.x = (op == 'h17) ? pc : 32'h0;
            e.y = ins & 32'hFFFF_F000;
        end
        if (!ok) begin
            e.x = 0; e.y = 0; e.f3 = 0; e.f7 = 0;
        end
        e.rd  = ins[11:7];
        e.ill = !ok;
        e.we  = ok && (ins[11:7] != 0);
        return e;
    endfunction

    // One clock of stimulus; entered and left 1 time unit after a rising edge.
    task automatic cyc(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                       input logic we, input logic [4:0] wr, input logic [31:0] wd,
                       input logic ordy);
        logic acc;
        in_valid = v; in_instr = ins; in_pc = pc;
        wb_en = we; wb_rd = wr; wb_data = wd; out_ready = ordy;
        @(negedge clk);
        chk("in_ready", 32'(in_ready), 32'(!slot_full || ordy));
        acc = v && (!slot_full || ordy);
        if (acc)
            q.push_back(model(ins, pc, opnd(ins[19:15], we, wr, wd), opnd(ins[24:20], we, wr, wd)));
        @(posedge clk); #1;
        if (we && wr != 0) mregs[wr] = wd;
        slot_full = acc ? 1'b1 : (ordy ? 1'b0 : slot_full);
    endtask

    function automatic logic [31:0] rnd_instr();
        logic [4:0] rd  = 5'($urandom_range(0, 7));
        logic [4:0] rs1 = 5'($urandom_range(0, 7));
        logic [4:0] rs2 = 5'($urandom_range(0, 7));
        logic [2:0] f3  = 3'($urandom);
        logic [6:0] f7;
        logic [31:0] w  = $urandom;
        case ($urandom_range(0, 3))
            0: f7 = 7'h00;
            1: f7 = 7'h20;
            default: f7 = 7'($urandom);
        endcase
        case ($urandom_range(0, 5))
            0: return {f7, rs2, rs1, f3, rd, 7'b0110011};
            1: return {f7, rs2, rs1, f3, rd, 7'b0010011};
            2: return {w[31:12], rd, 7'b0110111};
            3: return {w[31:12], rd, 7'b0010111};
            4: return {w[31:15], f3, rd, 7'b0010011};
            default: return w;
        endcase
    endfunction

    always @(negedge clk) begin
        if (!rst && started) begin
            chk("out_valid", 32'(out_valid), 32'(slot_full));
            if (out_valid) begin
                if (q.size() == 0) begin
                    chk("slot_unexpected", 32'(out_valid), 32'h0);
                end else begin
                    chk("x", out_x, q[0].x);
                    chk("y", out_y, q[0].y);
                    chk("funct3", 32'(out_funct3), 32'(q[0].f3));
                    chk("funct7", 32'(out_funct7), 32'(q[0].f7));
                    chk("rd", 32'(out_rd), 32'(q[0].rd));
                    chk("rd_we", 32'(out_rd_we), 32'(q[0].we));
                    chk("illegal", 32'(out_illegal), 32'(q[0].ill));
                    if (out_ready) void'(q.pop_front());
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, vectors=%0d", vectors);
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 32; i++) mregs[i] = 0;
        rst = 1'b1; in_valid = 0; in_instr = 0; in_pc = 0;
        wb_en = 0; wb_rd = 0; wb_data = 0; out_ready = 0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_in_ready", 32'(in_ready), 32'h1);
        chk("rst_x", out_x, 32'h0);
        chk("rst_y", out_y, 32'h0);
        chk("rst_rd_we", 32'(out_rd_we), 32'h0);
        @(posedge clk); #1;
        started = 1'b1;

        cyc(0, 0, 0, 1, 1, 32'd5, 1);
        cyc(0, 0, 0, 1, 2, 32'd3, 1);
        cyc(1, 32'h002081B3, 0, 0, 0, 0, 1);
        cyc(1, 32'h402081B3, 0, 0, 0, 0, 1);
        cyc(1, 32'hFFF08293, 0, 0, 0, 0, 1);
        cyc(1, 32'h4040D293, 0, 0, 0, 0, 0);
        cyc(1, 32'h123453B7, 0, 0, 0, 0, 0);
        cyc(1, 32'h123453B7, 0, 0, 0, 0, 0);
        cyc(1, 32'h123453B7, 0, 0, 0, 0, 1);
        cyc(1, 32'h002081B3, 0, 1, 1, 32'h1234, 1);
        cyc(1, 32'h00208033, 0, 0, 0, 0, 1);
        cyc(0, 0, 0, 1, 0, 32'hFFFF, 1);
        cyc(1, 32'h000002B3, 0, 0, 0, 0, 1);
        cyc(1, 32'h123453B7, 0, 0, 0, 0, 1);
        cyc(1, 32'h00001397, 32'h100, 0, 0, 0, 1);
        cyc(1, 32'h00000003, 0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0, 0, 1);

        for (int n = 0; n < 400; n++)
            cyc(($urandom_range(0, 3) != 0), rnd_instr(), $urandom,
                ($urandom_range(0, 1) == 1), 5'($urandom_range(0, 7)), $urandom,
                ($urandom_range(0, 3) != 0));

        cyc(1, 32'h002081B3, 0, 0, 0, 0, 0);
        cyc(1, 32'h002081B3, 0, 0, 0, 0, 0);
        rst = 1'b1;
        #2;
        chk("async_rst_out_valid", 32'(out_valid), 32'h0);
        chk("async_rst_in_ready", 32'(in_ready), 32'h1);
        q.delete();
        slot_full = 1'b0;
        for (int i = 0; i < 32; i++) mregs[i] = 0;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int r = 0; r < 32; r += 2)
            cyc(1, {7'h00, 5'(r + 1), 5'(r), 3'b000, 5'd3, 7'b0110011}, 0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0, 0, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule
